iact_glb_to_spad_router: RTL and testbench

- Input-activation (iact) router between the iact global buffer (GLB) bank and the PE cluster's activation scratchpads.
- On a load command from the control unit, it reads a contiguous block of act_size*act_size activation words from the GLB.
- It streams those words, one per cycle, to the PE cluster with a write-enable strobe.
- It is one of the routers in the cluster-level hierarchical mesh, alongside the weight router.

---
 rtl/iact_router_pkg.sv | 20 ++
 rtl/iact_glb_to_spad_router_if.sv | 39 +++
 rtl/iact_addr_gen.sv | 81 ++++++++
 rtl/iact_glb_to_spad_router.sv | 85 ++++++++
 tb/tb_iact_glb_to_spad_router.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/iact_router_pkg.sv
// Shared types and helpers for the iact GLB-to-spad router.
//   state_e   : transfer FSM states
//   N         : default transfer length (act_size*act_size for the default act_size)
//   cnt_width : width of a counter that must hold 0..n
package iact_router_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  localparam int unsigned ActSizeDefault = 5;
  localparam int unsigned N = ActSizeDefault * ActSizeDefault;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/iact_glb_to_spad_router_if.sv
// Bus bundle between the iact router, the GLB bank, the control unit and the PE cluster.
//   load_spad_ctrl    : load command (rising edge starts a transfer)
//   r_data_glb_iact   : GLB read data, valid one cycle after the request
//   read_req_glb_iact : GLB read request
//   r_addr_glb_iact   : GLB read address
//   w_data_spad       : activation word to the PE cluster
//   load_en_spad      : write strobe qualifying w_data_spad
// master = router side, slave = environment (GLB / control / PE cluster).
interface iact_glb_to_spad_router_if #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10
);

  logic                         load_spad_ctrl;
  logic [DATA_BITWIDTH-1:0]     r_data_glb_iact;
  logic                         read_req_glb_iact;
  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_iact;
  logic [DATA_BITWIDTH-1:0]     w_data_spad;
  logic                         load_en_spad;

  modport master (
    input  load_spad_ctrl,
    input  r_data_glb_iact,
    output read_req_glb_iact,
    output r_addr_glb_iact,
    output w_data_spad,
    output load_en_spad
  );

  modport slave (
    output load_spad_ctrl,
    output r_data_glb_iact,
    input  read_req_glb_iact,
    input  r_addr_glb_iact,
    input  w_data_spad,
    input  load_en_spad
  );

endinterface

// File: rtl/iact_addr_gen.sv
// Word counter, GLB read-address generator and spad write pointer for one transfer.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a transfer (only asserted while the router is idle)
//   strobe     : one spad write happened this cycle
//   busy       : GLB read phase active (doubles as the registered read request)
//   last       : current read is the final word of the transfer
//   glb_addr   : registered GLB read address
module iact_addr_gen
  import iact_router_pkg::*;
#(
  parameter int unsigned N                  = 25,
  parameter int unsigned ADDR_BITWIDTH_GLB  = 10,
  parameter int unsigned ADDR_BITWIDTH_SPAD = 9,
  parameter int unsigned A_READ_ADDR        = 0,
  parameter int unsigned A_LOAD_ADDR        = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         strobe,
  output logic                         busy,
  output logic                         last,
  output logic [ADDR_BITWIDTH_GLB-1:0] glb_addr
);

  localparam int unsigned CntW = cnt_width(N);
  // Base addresses are truncated so an out-of-range base wraps like the counter does.
  localparam logic [ADDR_BITWIDTH_GLB-1:0]  BaseAddr = ADDR_BITWIDTH_GLB'(A_READ_ADDR);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] LoadAddr = ADDR_BITWIDTH_SPAD'(A_LOAD_ADDR);
  localparam logic [CntW-1:0]               LastCnt  = CntW'(N - 1);

  logic                          busy_q, busy_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [ADDR_BITWIDTH_GLB-1:0]  addr_q, addr_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] ptr_q, ptr_d;

  assign last     = busy_q && (cnt_q == LastCnt);
  assign busy     = busy_q;
  assign glb_addr = addr_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      addr_d = BaseAddr;
      ptr_d  = LoadAddr;
    end else begin
      if (busy_q) begin
        if (last) begin
          busy_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          addr_d = addr_q + ADDR_BITWIDTH_GLB'(1);
        end
      end
      // Pointer names the spad slot of the next write; wraps at 2^ADDR_BITWIDTH_SPAD.
      if (strobe) begin
        ptr_d = ptr_q + ADDR_BITWIDTH_SPAD'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: rtl/iact_glb_to_spad_router.sv
// Input-activation router: on a rising edge of load_spad_ctrl it reads act_size*act_size
// contiguous words from the iact GLB and streams them, one per cycle, to the PE cluster.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : GLB read port, load command and spad write port (master side)
module iact_glb_to_spad_router
  import iact_router_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH      = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB  = 10,
  parameter int unsigned ADDR_BITWIDTH_SPAD = 9,
  parameter int unsigned kernel_size        = 3,
  parameter int unsigned act_size           = 5,
  parameter int unsigned A_READ_ADDR        = 0,
  parameter int unsigned A_LOAD_ADDR        = 100
) (
  input logic                        clk,
  input logic                        reset,
  iact_glb_to_spad_router_if.master  bus
);

  localparam int unsigned NWords = act_size * act_size;

  // kernel_size does not shape the transfer; it is only sanity-checked here.
  if (act_size == 0 || kernel_size == 0) begin : g_bad_dims
    $error("act_size and kernel_size must be nonzero");
  end

  state_e state_q, state_d;
  logic   cmd_q;
  logic   start;
  logic   busy;
  logic   last;
  logic   load_en_q;
  logic [ADDR_BITWIDTH_GLB-1:0] glb_addr;
  logic [DATA_BITWIDTH-1:0]     w_data;

  // Edges outside IDLE are dropped, and a held level only produces one edge.
  assign start = (state_q == StIdle) && bus.load_spad_ctrl && !cmd_q;

  iact_addr_gen #(
    .N                  (NWords),
    .ADDR_BITWIDTH_GLB  (ADDR_BITWIDTH_GLB),
    .ADDR_BITWIDTH_SPAD (ADDR_BITWIDTH_SPAD),
    .A_READ_ADDR        (A_READ_ADDR),
    .A_LOAD_ADDR        (A_LOAD_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .strobe   (load_en_q),
    .busy     (busy),
    .last     (last),
    .glb_addr (glb_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (last)  state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= 1'b0;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= bus.load_spad_ctrl;
      // GLB data lags the request by one cycle, so the strobe does too.
      load_en_q <= busy;
    end
  end

  assign w_data                = load_en_q ? bus.r_data_glb_iact : '0;
  assign bus.read_req_glb_iact = busy;
  assign bus.r_addr_glb_iact   = glb_addr;
  assign bus.w_data_spad       = w_data;
  assign bus.load_en_spad      = load_en_q;

endmodule

// File: tb/tb_iact_glb_to_spad_router.sv
// Bench for iact_glb_to_spad_router: two instances (base 0 and base 1020) share the command
// and reset; each has its own GLB model. A transfer-level model predicts every cycle.
module tb_iact_glb_to_spad_router;

  localparam int unsigned N     = 25;
  localparam int unsigned BaseB = 1020;
  localparam int unsigned AMask = 1023;

  logic clk = 1'b0;
  logic reset;
  logic cmd;

  always #5 clk = ~clk;

  iact_glb_to_spad_router_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10)) bus_a ();
  iact_glb_to_spad_router_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10)) bus_b ();

  iact_glb_to_spad_router #(.A_READ_ADDR(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  iact_glb_to_spad_router #(.A_READ_ADDR(BaseB)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];

  assign bus_a.load_spad_ctrl = cmd;
  assign bus_b.load_spad_ctrl = cmd;

  // GLB banks: registered read, data one cycle after the request.
  always @(posedge clk) begin
    if (bus_a.read_req_glb_iact) bus_a.r_data_glb_iact <= mem_a[bus_a.r_addr_glb_iact];
    if (bus_b.read_req_glb_iact) bus_b.r_data_glb_iact <= mem_b[bus_b.r_addr_glb_iact];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t_start  = -1;  // posedge index at which the current/last transfer was accepted
  bit prev_cmd = 1'b0;
  int strobes  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_idle();
    return (t_start < 0) || (cyc >= t_start + int'(N) + 1);
  endfunction

  task automatic check_outputs();
    int  k;
    bit  exp_req, exp_en;
    k       = cyc - t_start;
    exp_req = (t_start >= 0) && (k >= 0) && (k < int'(N));
    exp_en  = (t_start >= 0) && (k >= 1) && (k <= int'(N));
    check_eq("a_req", 32'(bus_a.read_req_glb_iact), 32'(exp_req));
    check_eq("b_req", 32'(bus_b.read_req_glb_iact), 32'(exp_req));
    if (exp_req) begin
      check_eq("a_addr", 32'(bus_a.r_addr_glb_iact), 32'(k & AMask));
      check_eq("b_addr", 32'(bus_b.r_addr_glb_iact), 32'((BaseB + k) & AMask));
    end
    if (reset) begin
      check_eq("a_addr_rst", 32'(bus_a.r_addr_glb_iact), 32'd0);
      check_eq("b_addr_rst", 32'(bus_b.r_addr_glb_iact), 32'd0);
    end
    check_eq("a_en", 32'(bus_a.load_en_spad), 32'(exp_en));
    check_eq("b_en", 32'(bus_b.load_en_spad), 32'(exp_en));
    check_eq("a_data", 32'(bus_a.w_data_spad), exp_en ? 32'(mem_a[(k - 1) & AMask]) : 32'd0);
    check_eq("b_data", 32'(bus_b.w_data_spad),
             exp_en ? 32'(mem_b[(BaseB + k - 1) & AMask]) : 32'd0);
    if (bus_a.load_en_spad === 1'b1) strobes++;
  endtask

  // Advance one cycle: model sees the inputs present at the posedge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) begin
      t_start  = -1;
      prev_cmd = 1'b0;
    end else begin
      if (cmd && !prev_cmd && ((t_start < 0) || (cyc >= t_start + int'(N) + 2))) t_start = cyc;
      prev_cmd = cmd;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse();
    cmd = 1'b1;
    tick();
    cmd = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic async_reset(input int hold);
    #2;
    reset = 1'b1;
    #1;
    check_eq("a_req_async", 32'(bus_a.read_req_glb_iact), 32'd0);
    check_eq("a_addr_async", 32'(bus_a.r_addr_glb_iact), 32'd0);
    check_eq("a_en_async", 32'(bus_a.load_en_spad), 32'd0);
    check_eq("a_data_async", 32'(bus_a.w_data_spad), 32'd0);
    check_eq("b_en_async", 32'(bus_b.load_en_spad), 32'd0);
    t_start  = -1;
    prev_cmd = 1'b0;
    @(negedge clk);
    run(hold);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 16'(i + 1);
      mem_b[i] = 16'($urandom);
    end
    bus_a.r_data_glb_iact = '0;
    bus_b.r_data_glb_iact = '0;
    cmd   = 1'b0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // Basic load
    strobes = 0;
    pulse();
    run(30);
    check_eq("basic_strobes", 32'(strobes), 32'(N));

    // Held command: one transfer only
    strobes = 0;
    cmd = 1'b1;
    run(40);
    cmd = 1'b0;
    run(5);
    check_eq("held_strobes", 32'(strobes), 32'(N));

    // Second edge at READ cycle 10 is ignored
    strobes = 0;
    pulse();
    run(9);
    pulse();
    run(30);
    check_eq("during_strobes", 32'(strobes), 32'(N));

    // Reset at READ cycle 12, then restart from address 0
    pulse();
    run(11);
    async_reset(2);
    run(2);
    strobes = 0;
    pulse();
    run(30);
    check_eq("restart_strobes", 32'(strobes), 32'(N));

    // Back-to-back: new edge on the first IDLE cycle
    strobes = 0;
    pulse();
    while (!model_idle()) tick();
    pulse();
    check_eq("b2b_accepted", 32'(t_start), 32'(cyc));
    run(30);
    check_eq("b2b_strobes", 32'(strobes), 32'(2 * N));

    // Random command traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      cmd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        cmd = 1'b0;
        async_reset($urandom_range(1, 2));
      end else begin
        tick();
      end
    end
    cmd = 1'b0;
    run(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
